// File: rtl/ram_dual_port_be.sv
// Word-organised dual-port RAM with byte-lane writes, 1- or 2-stage pipelined reads,
// selectable read-during-write behaviour, out-of-range detection and a sequential clear engine.
module ram_dual_port_be #(
    parameter int WIDTH_DATA        = 16,
    parameter int DEPTH             = 8,
    parameter int WIDTH_ADDRESS     = 20,
    parameter int READ_LATENCY      = 1,
    parameter int READ_DURING_WRITE = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear_start,
    output logic                      busy,
    input  logic                      write_enable,
    input  logic [WIDTH_ADDRESS-1:0]  write_address,
    input  logic [WIDTH_DATA-1:0]     write_data,
    input  logic [WIDTH_DATA/8-1:0]   write_byte_enable,
    input  logic                      read_enable,
    input  logic [WIDTH_ADDRESS-1:0]  read_address,
    output logic [WIDTH_DATA-1:0]     read_data,
    output logic                      read_valid,
    output logic                      address_error
);

    localparam int LANES = WIDTH_DATA / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH_ADDRESS-1:0] DEPTH_ADDR = WIDTH_ADDRESS'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  count_reg, count_next;

    logic              wr_accept, rd_accept;
    logic              wr_in_range, rd_in_range;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              fwd_hit;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [WIDTH_DATA-1:0] mem_wdata;
    logic [LANES-1:0]  mem_be;

    logic [WIDTH_DATA-1:0] rd_lane_data;
    logic [WIDTH_DATA-1:0] rd_data_next;

    logic                  s1_valid_reg, s1_err_reg, wr_err_reg;
    logic [WIDTH_DATA-1:0] s1_data_reg;

    // Clear engine: state register and next-state logic
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clear_start) begin
                    state_next = ST_CLEAR;
                    count_next = '0;
                end
            end
            ST_CLEAR: begin
                if (count_reg == LAST_IDX) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    assign busy = (state_reg == ST_CLEAR);

    // Request qualification; range check is over the full address width
    assign wr_accept   = write_enable & ~busy;
    assign rd_accept   = read_enable & ~busy;
    assign wr_in_range = (write_address < DEPTH_ADDR);
    assign rd_in_range = (read_address < DEPTH_ADDR);
    assign wr_idx      = write_address[IDX_W-1:0];
    assign rd_idx      = read_address[IDX_W-1:0];

    assign fwd_hit = (READ_DURING_WRITE != 0) && wr_accept && wr_in_range && rd_in_range
                     && (write_address == read_address);

    // The clear engine owns the single write port while busy; user writes are dropped then
    assign mem_we    = busy | (wr_accept & wr_in_range);
    assign mem_idx   = busy ? count_reg : wr_idx;
    assign mem_wdata = busy ? '0 : write_data;
    assign mem_be    = busy ? {LANES{1'b1}} : write_byte_enable;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clock) begin
                if (mem_we && mem_be[gi]) begin
                    lane_mem[mem_idx] <= mem_wdata[8*gi +: 8];
                end
            end

            // Forwarded lanes see the incoming byte, others the stored one
            assign rd_lane_data[8*gi +: 8] = (fwd_hit && write_byte_enable[gi])
                                             ? write_data[8*gi +: 8]
                                             : lane_mem[rd_idx];
        end
    endgenerate

    assign rd_data_next = rd_in_range ? rd_lane_data : '0;

    // First read stage plus write-side error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            wr_err_reg   <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= rd_accept;
            s1_err_reg   <= rd_accept & ~rd_in_range;
            wr_err_reg   <= wr_accept & ~wr_in_range;
            if (rd_accept) begin
                s1_data_reg <= rd_data_next;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid_reg, s2_err_reg;
            logic [WIDTH_DATA-1:0] s2_data_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s2_valid_reg <= 1'b0;
                    s2_err_reg   <= 1'b0;
                    s2_data_reg  <= '0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    s2_err_reg   <= s1_err_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data_reg;
                    end
                end
            end

            assign read_valid    = s2_valid_reg;
            assign read_data     = s2_data_reg;
            assign address_error = s2_err_reg | wr_err_reg;
        end else begin : g_lat1
            assign read_valid    = s1_valid_reg;
            assign read_data     = s1_data_reg;
            assign address_error = s1_err_reg | wr_err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dual_port_be.sv
// Directed bench: one stimulus stream drives a latency-1/old-data RAM and a
// latency-2/new-data RAM side by side, each checked against hand-computed values.
module tb_ram_dual_port_be;

    logic        clock;
    logic        reset;
    logic        clear_start;
    logic        write_enable;
    logic [19:0] write_address;
    logic [15:0] write_data;
    logic [1:0]  write_byte_enable;
    logic        read_enable;
    logic [19:0] read_address;

    logic        a_busy, b_busy;
    logic [15:0] a_read_data, b_read_data;
    logic        a_read_valid, b_read_valid;
    logic        a_address_error, b_address_error;

    int compared;
    int mismatched;

    ram_dual_port_be #(
        .WIDTH_DATA(16), .DEPTH(8), .WIDTH_ADDRESS(20),
        .READ_LATENCY(1), .READ_DURING_WRITE(0)
    ) dut_a (
        .clock(clock), .reset(reset), .clear_start(clear_start), .busy(a_busy),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .write_byte_enable(write_byte_enable),
        .read_enable(read_enable), .read_address(read_address),
        .read_data(a_read_data), .read_valid(a_read_valid),
        .address_error(a_address_error)
    );

    ram_dual_port_be #(
        .WIDTH_DATA(16), .DEPTH(8), .WIDTH_ADDRESS(20),
        .READ_LATENCY(2), .READ_DURING_WRITE(1)
    ) dut_b (
        .clock(clock), .reset(reset), .clear_start(clear_start), .busy(b_busy),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .write_byte_enable(write_byte_enable),
        .read_enable(read_enable), .read_address(read_address),
        .read_data(b_read_data), .read_valid(b_read_valid),
        .address_error(b_address_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        clear_start  = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_byte_enable = 2'b00;
    endtask

    task automatic do_write(input logic [19:0] addr, input logic [15:0] data, input logic [1:0] be);
        write_enable = 1'b1;
        write_address = addr;
        write_data = data;
        write_byte_enable = be;
        tick();
        idle();
    endtask

    initial begin
        int busy_cycles;
        logic saw_valid;
        logic [15:0] exp_word;

        compared = 0;
        mismatched = 0;
        reset = 1'b0;
        idle();
        write_address = '0;
        write_data = '0;
        read_address = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_a_data", a_read_data, 16'h0000);
        check("rst_a_valid", a_read_valid, 1'b0);
        check("rst_a_err", a_address_error, 1'b0);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_b_data", b_read_data, 16'h0000);
        check("rst_b_valid", b_read_valid, 1'b0);
        reset = 1'b1;
        tick();
        $display("step reset released");

        // Full write then read, latency 1 vs 2
        do_write(20'h00001, 16'h0001, 2'b11);
        do_write(20'h00000, 16'h0F0F, 2'b11);
        read_enable = 1'b1; read_address = 20'h00001;
        tick();
        read_enable = 1'b0;
        check("rd1_a_valid", a_read_valid, 1'b1);
        check("rd1_a_data", a_read_data, 16'h0001);
        check("rd1_a_err", a_address_error, 1'b0);
        check("rd1_b_valid_early", b_read_valid, 1'b0);
        tick();
        check("rd1_a_valid_drop", a_read_valid, 1'b0);
        check("rd1_a_hold", a_read_data, 16'h0001);
        check("rd1_b_valid", b_read_valid, 1'b1);
        check("rd1_b_data", b_read_data, 16'h0001);
        $display("step write/read word 1 done");

        // Byte-lane merge and zero byte-enable
        do_write(20'h00003, 16'hABCD, 2'b11);
        do_write(20'h00003, 16'h1234, 2'b01);
        do_write(20'h00003, 16'hFFFF, 2'b00);
        read_enable = 1'b1; read_address = 20'h00003;
        tick();
        read_enable = 1'b0;
        check("be_a_data", a_read_data, 16'hAB34);
        tick();
        check("be_b_data", b_read_data, 16'hAB34);
        $display("step byte-lane merge done");

        // Out-of-range read
        read_enable = 1'b1; read_address = 20'h00010;
        tick();
        read_enable = 1'b0;
        check("oor_rd_a_valid", a_read_valid, 1'b1);
        check("oor_rd_a_data", a_read_data, 16'h0000);
        check("oor_rd_a_err", a_address_error, 1'b1);
        check("oor_rd_b_err_early", b_address_error, 1'b0);
        tick();
        check("oor_rd_a_err_drop", a_address_error, 1'b0);
        check("oor_rd_b_valid", b_read_valid, 1'b1);
        check("oor_rd_b_data", b_read_data, 16'h0000);
        check("oor_rd_b_err", b_address_error, 1'b1);
        // High address bit must not wrap onto word 1
        read_enable = 1'b1; read_address = 20'h80001;
        tick();
        read_enable = 1'b0;
        check("oor_hi_a_err", a_address_error, 1'b1);
        check("oor_hi_a_data", a_read_data, 16'h0000);
        tick();
        // Out-of-range write, then word 0 must be untouched
        do_write(20'h00010, 16'hFFFF, 2'b11);
        check("oor_wr_a_err", a_address_error, 1'b1);
        check("oor_wr_b_err", b_address_error, 1'b1);
        check("oor_wr_a_valid", a_read_valid, 1'b0);
        tick();
        check("oor_wr_err_drop", a_address_error, 1'b0);
        read_enable = 1'b1; read_address = 20'h00000;
        tick();
        read_enable = 1'b0;
        check("oor_wr_word0", a_read_data, 16'h0F0F);
        tick();
        $display("step out-of-range done");

        // Same-edge read and write
        do_write(20'h00002, 16'h1111, 2'b11);
        write_enable = 1'b1; write_address = 20'h00002; write_data = 16'h5555;
        write_byte_enable = 2'b11;
        read_enable = 1'b1; read_address = 20'h00002;
        tick();
        idle();
        check("rdw_old_a", a_read_data, 16'h1111);
        tick();
        check("rdw_new_b", b_read_data, 16'h5555);
        write_enable = 1'b1; write_address = 20'h00002; write_data = 16'h00AA;
        write_byte_enable = 2'b01;
        read_enable = 1'b1; read_address = 20'h00002;
        tick();
        idle();
        check("rdw_old_a_part", a_read_data, 16'h5555);
        tick();
        check("rdw_merge_b", b_read_data, 16'h55AA);
        $display("step read-during-write done");

        // Fill, clear, requests during busy dropped
        for (int i = 0; i < 8; i++) do_write(20'(i), 16'h1000 + 16'(i), 2'b11);
        clear_start = 1'b1;
        tick();
        check("clr_busy_a", a_busy, 1'b1);
        busy_cycles = 1;
        saw_valid = 1'b0;
        read_enable = 1'b1; read_address = 20'h00001;
        write_enable = 1'b1; write_address = 20'h00005; write_data = 16'hDEAD;
        write_byte_enable = 2'b11;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (a_read_valid || b_read_valid || a_address_error) saw_valid = 1'b1;
            if (!a_busy) break;
            busy_cycles++;
        end
        idle();
        check("clr_busy_cycles", busy_cycles, 8);
        check("clr_b_busy_done", b_busy, 1'b0);
        check("clr_dropped_read", saw_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            read_enable = 1'b1; read_address = 20'(i);
            tick();
            check("clr_a_zero", a_read_data, 16'h0000);
            if (i > 0) check("clr_b_zero", b_read_data, 16'h0000);
        end
        read_enable = 1'b0;
        tick();
        check("clr_b_last", b_read_data, 16'h0000);
        check("clr_b_last_valid", b_read_valid, 1'b1);
        tick();
        $display("step clear done");

        // Pipelined back-to-back reads
        do_write(20'h00000, 16'hA0A0, 2'b11);
        do_write(20'h00001, 16'hB1B1, 2'b11);
        do_write(20'h00002, 16'hC2C2, 2'b11);
        read_enable = 1'b1; read_address = 20'h00000;
        tick();
        check("pipe0_a", a_read_data, 16'hA0A0);
        check("pipe0_b_valid", b_read_valid, 1'b0);
        read_address = 20'h00001;
        tick();
        check("pipe1_a", a_read_data, 16'hB1B1);
        check("pipe1_b", b_read_data, 16'hA0A0);
        check("pipe1_b_valid", b_read_valid, 1'b1);
        read_address = 20'h00002;
        tick();
        read_enable = 1'b0;
        check("pipe2_a", a_read_data, 16'hC2C2);
        check("pipe2_b", b_read_data, 16'hB1B1);
        tick();
        check("pipe3_a_valid", a_read_valid, 1'b0);
        check("pipe3_b", b_read_data, 16'hC2C2);
        check("pipe3_b_valid", b_read_valid, 1'b1);
        tick();
        check("pipe4_b_valid", b_read_valid, 1'b0);
        $display("step pipelined reads done");

        // Reset in the middle of a clear
        for (int i = 0; i < 8; i++) do_write(20'(i), 16'h2000 + 16'(i), 2'b11);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (4) tick();
        check("midclr_busy_before", a_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("midclr_a_busy", a_busy, 1'b0);
        check("midclr_b_busy", b_busy, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            read_enable = 1'b1; read_address = 20'(i);
            tick();
            exp_word = (i < 4) ? 16'h0000 : (16'h2000 + 16'(i));
            check("midclr_word", a_read_data, exp_word);
        end
        read_enable = 1'b0;
        tick();
        $display("step reset mid-clear done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_dual_port_be.md
Name: ram_dual_port_be

Overview:
- Parametrised successor of the codebase's simple RAM: one write port and one read port, sharing one clock.
- Adds per-byte write enables, a configurable pipelined read latency, and a selectable read-during-write policy.
- Adds out-of-range address detection and a hardware clear engine.
- Used as the 8086 word-organised data store: 16-bit words with independent even/odd byte lanes, behind the bus interface unit.

Parameters:
WIDTH_DATA, 16, word width in bits; must be a multiple of 8
DEPTH, 8, number of words
WIDTH_ADDRESS, 20, address width in bits (8086 physical address space)
READ_LATENCY, 1, clock edges from read accept to read_valid; legal values 1 or 2
READ_DURING_WRITE, 0, same-address read and write on one edge: 0 returns old data, 1 returns new merged data

Ports:
clock  input  1  system clock, rising edge active
reset  input  1  asynchronous, active-low reset; one clock domain only
clear_start  input  1  request to zero the whole array
busy  output  1  high while the clear engine runs
write_enable  input  1  write request
write_address  input  WIDTH_ADDRESS  word address for the write
write_data  input  WIDTH_DATA  write data
write_byte_enable  input  WIDTH_DATA/8  bit i enables byte lane i (bits 8i+7:8i)
read_enable  input  1  read request
read_address  input  WIDTH_ADDRESS  word address for the read
read_data  output  WIDTH_DATA  read result
read_valid  output  1  one-cycle pulse qualifying read_data
address_error  output  1  one-cycle pulse flagging an out-of-range access

Behaviour:
- Reset (reset=0, asynchronous):
  - read_data=0, read_valid=0, address_error=0, busy=0.
  - FSM goes to IDLE, clear counter=0, read pipeline flushed.
  - Memory contents are not touched by reset.
- FSM states:
  - IDLE: on a rising edge with clear_start=1, go to CLEAR, set counter=0, set busy=1 from the next cycle.
  - CLEAR: each edge writes all-zero to word[counter], then counter+1. The edge at counter=DEPTH-1 returns to IDLE. busy is high for exactly DEPTH cycles.
  - clear_start while busy=1 is ignored.
- Accept rules:
  - A write is accepted on a rising edge when write_enable=1 and busy=0.
  - A read is accepted on a rising edge when read_enable=1 and busy=0.
  - Requests while busy=1 are dropped: no write, no read_valid, no address_error.
- Write (address < DEPTH): only byte lanes with write_byte_enable=1 are updated; other lanes keep their value. write_byte_enable=0 means no change.
- Read latency and data:
  - read_valid pulses exactly READ_LATENCY cycles after the accept edge.
  - Back-to-back reads are fully pipelined, one per cycle, in order.
  - read_data holds its last value when read_valid=0.
  - Reads already in the pipeline when a clear starts still complete normally.
- Out of range (address >= DEPTH):
  - Write: ignored; address_error pulses in the cycle after the accept edge.
  - Read: read_valid still pulses with read_data=0; address_error pulses in the same cycle as that read_valid.
  - If both sources fall in the same cycle, they produce a single pulse (OR).
- Same-address read and write on one edge:
  - READ_DURING_WRITE=0: read returns the pre-write word.
  - READ_DURING_WRITE=1: read returns the post-write word, merged per byte lane.
  - Different addresses do not interact.
- Reset mid-clear: FSM returns to IDLE and busy=0 asynchronously. Words already cleared stay zero; the rest keep prior contents.
- Address comparison is unsigned over the full WIDTH_ADDRESS; no wrap-around.

Test Plan:
- Write 16'h0001 @0x00001 with byte enables 2'b11, then read 0x00001 (READ_LATENCY=1) -> read_valid pulses 1 cycle after the accept edge, read_data=16'h0001.
- Write 16'hABCD @3 with be=2'b11, then 16'h1234 @3 with be=2'b01, then read 3 -> 16'hAB34.
- Read 0x00010 with DEPTH=8 -> read_valid=1, read_data=0, address_error=1 in the same cycle. Write 0x00010 -> address_error pulses next cycle; a following read of word 0 is unchanged.
- Same-edge write 16'h5555 and read @2, word 2 previously 16'h1111 -> READ_DURING_WRITE=0 gives 16'h1111; READ_DURING_WRITE=1 gives 16'h5555.
- Fill words 0-7, pulse clear_start -> busy high for exactly 8 cycles; a read issued while busy gives no read_valid; reads afterwards return 0 for all words.
- READ_LATENCY=2, reads @0,1,2 on consecutive edges -> three consecutive read_valid pulses, in order. Assert reset=0 at clear counter=4 -> busy drops immediately; words 0-3 read 0, words 4-7 keep prior data.
